// File: rtl/ctrl_pipeline_if.sv
// -----------------------------------------------------------------------------
// ctrl_pipeline_if
// Bundles the signals between the ID-stage opcode decoder / datapath and the
// pipeline control block.
//   master : decoder/datapath side - drives the ID control word, the ID register
//            fields and the MEM-stage branch resolution; observes everything else.
//   slave  : ctrl_pipeline side - consumes the ID word, produces the hazard
//            controls, the per-stage control outputs, forwarding selects and the
//            stall/flush event counters.
// -----------------------------------------------------------------------------
interface ctrl_pipeline_if #(
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 2,
    parameter int CNT_W   = 16
);
    // ID-stage control word and register fields
    logic               id_valid_i;
    logic               id_RegDst_i;
    logic               id_RegWrite_i;
    logic               id_ALUSrc_i;
    logic               id_Branch_i;
    logic               id_MemRead_i;
    logic               id_MemWrite_i;
    logic               id_MemtoReg_i;
    logic [ALUOP_W-1:0] id_ALUop_i;
    logic [REG_W-1:0]   id_rs_i;
    logic [REG_W-1:0]   id_rt_i;
    logic [REG_W-1:0]   id_rd_i;
    // Branch resolved taken in MEM
    logic               mem_br_taken_i;

    // Hazard controls
    logic               stall_o;
    logic               flush_o;
    // EX-stage controls
    logic               ex_RegDst_o;
    logic               ex_ALUSrc_o;
    logic [ALUOP_W-1:0] ex_ALUop_o;
    logic [REG_W-1:0]   ex_wreg_o;
    logic [1:0]         fwd_a_o;
    logic [1:0]         fwd_b_o;
    // MEM-stage controls
    logic               mem_Branch_o;
    logic               mem_MemRead_o;
    logic               mem_MemWrite_o;
    logic [REG_W-1:0]   mem_wreg_o;
    // WB-stage controls
    logic               wb_RegWrite_o;
    logic               wb_MemtoReg_o;
    logic [REG_W-1:0]   wb_wreg_o;
    // Event counters
    logic [CNT_W-1:0]   stall_cnt_o;
    logic [CNT_W-1:0]   flush_cnt_o;

    modport master (
        output id_valid_i, id_RegDst_i, id_RegWrite_i, id_ALUSrc_i, id_Branch_i,
               id_MemRead_i, id_MemWrite_i, id_MemtoReg_i, id_ALUop_i,
               id_rs_i, id_rt_i, id_rd_i, mem_br_taken_i,
        input  stall_o, flush_o, ex_RegDst_o, ex_ALUSrc_o, ex_ALUop_o, ex_wreg_o,
               fwd_a_o, fwd_b_o, mem_Branch_o, mem_MemRead_o, mem_MemWrite_o,
               mem_wreg_o, wb_RegWrite_o, wb_MemtoReg_o, wb_wreg_o,
               stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  id_valid_i, id_RegDst_i, id_RegWrite_i, id_ALUSrc_i, id_Branch_i,
               id_MemRead_i, id_MemWrite_i, id_MemtoReg_i, id_ALUop_i,
               id_rs_i, id_rt_i, id_rd_i, mem_br_taken_i,
        output stall_o, flush_o, ex_RegDst_o, ex_ALUSrc_o, ex_ALUop_o, ex_wreg_o,
               fwd_a_o, fwd_b_o, mem_Branch_o, mem_MemRead_o, mem_MemWrite_o,
               mem_wreg_o, wb_RegWrite_o, wb_MemtoReg_o, wb_wreg_o,
               stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/ctrl_pipeline.sv
// -----------------------------------------------------------------------------
// ctrl_pipeline
// Carries the decoder's per-instruction control word through the ID/EX, EX/MEM
// and MEM/WB pipeline registers together with the destination register number.
// Detects load-use hazards (stall + EX bubble), squashes wrong-path work when a
// branch in MEM resolves taken (flush), and produces the EX-stage forwarding
// selects.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : asynchronous, active-high reset
//   bus  : ctrl_pipeline_if.slave
//          in : id_* control word / register fields, mem_br_taken_i
//          out: stall_o, flush_o (combinational), ex_*/mem_*/wb_* stage
//               controls, fwd_a_o/fwd_b_o (00 regfile, 10 MEM, 01 WB),
//               stall_cnt_o/flush_cnt_o (saturating event counters)
// -----------------------------------------------------------------------------
module ctrl_pipeline #(
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 2,
    parameter int CNT_W   = 16,
    parameter int LU_EN   = 1
) (
    input  logic             clk,
    input  logic             rst,
    ctrl_pipeline_if.slave   bus
);

    // ID/EX register: EX keeps rs/rt for the forwarding compare
    typedef struct packed {
        logic               valid;
        logic               reg_dst;
        logic               reg_write;
        logic               alu_src;
        logic               branch;
        logic               mem_read;
        logic               mem_write;
        logic               memto_reg;
        logic [ALUOP_W-1:0] alu_op;
        logic [REG_W-1:0]   rs;
        logic [REG_W-1:0]   rt;
        logic [REG_W-1:0]   wreg;
    } ex_t;

    // EX/MEM register
    typedef struct packed {
        logic               valid;
        logic               reg_write;
        logic               branch;
        logic               mem_read;
        logic               mem_write;
        logic               memto_reg;
        logic [REG_W-1:0]   wreg;
    } mem_t;

    // MEM/WB register
    typedef struct packed {
        logic               valid;
        logic               reg_write;
        logic               memto_reg;
        logic [REG_W-1:0]   wreg;
    } wb_t;

    localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic             LU_ON    = (LU_EN != 0);

    // Stage registers and their next-state values
    ex_t              ex_q,  ex_d;
    mem_t             mem_q, mem_d;
    wb_t              wb_q,  wb_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Decoded ID word as it would enter EX, plus hazard terms
    ex_t              id_ex_s;
    logic             uses_rt_s;
    logic             hazard_s;
    logic             stall_s;
    logic             flush_s;

    // EX/MEM image of an EX-stage entry (a bubble maps to a bubble)
    function automatic mem_t ex_to_mem(input ex_t e);
        mem_t m;
        m.valid     = e.valid;
        m.reg_write = e.reg_write;
        m.branch    = e.branch;
        m.mem_read  = e.mem_read;
        m.mem_write = e.mem_write;
        m.memto_reg = e.memto_reg;
        m.wreg      = e.wreg;
        return m;
    endfunction

    // MEM/WB image of a MEM-stage entry
    function automatic wb_t mem_to_wb(input mem_t m);
        wb_t w;
        w.valid     = m.valid;
        w.reg_write = m.reg_write;
        w.memto_reg = m.memto_reg;
        w.wreg      = m.wreg;
        return w;
    endfunction

    // Forward select for one EX source; MEM has priority, r0 is never forwarded
    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                           input mem_t m, input wb_t w);
        logic [1:0] sel;
        if (m.valid && m.reg_write && (m.wreg != REG_ZERO) && (m.wreg == src)) begin
            sel = 2'b10;
        end else if (w.valid && w.reg_write && (w.wreg != REG_ZERO) && (w.wreg == src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Build the EX-stage entry for the instruction currently in ID
    always_comb begin
        id_ex_s = {$bits(ex_t){1'b0}};
        if (bus.id_valid_i) begin
            id_ex_s.valid     = 1'b1;
            id_ex_s.reg_dst   = bus.id_RegDst_i;
            id_ex_s.reg_write = bus.id_RegWrite_i;
            id_ex_s.alu_src   = bus.id_ALUSrc_i;
            id_ex_s.branch    = bus.id_Branch_i;
            id_ex_s.mem_read  = bus.id_MemRead_i;
            id_ex_s.mem_write = bus.id_MemWrite_i;
            id_ex_s.memto_reg = bus.id_MemtoReg_i;
            id_ex_s.alu_op    = bus.id_ALUop_i;
            id_ex_s.rs        = bus.id_rs_i;
            id_ex_s.rt        = bus.id_rt_i;
            id_ex_s.wreg      = bus.id_RegDst_i ? bus.id_rd_i : bus.id_rt_i;
        end else begin
            id_ex_s = {$bits(ex_t){1'b0}};
        end
    end

    // Load-use detection: a load in EX whose target is read by the ID instruction.
    // A taken branch squashes ID anyway, so the stall is suppressed under flush.
    always_comb begin
        uses_rt_s = ~bus.id_ALUSrc_i | bus.id_MemWrite_i;
        hazard_s  = ex_q.valid & ex_q.mem_read & (ex_q.wreg != REG_ZERO)
                  & ((ex_q.wreg == bus.id_rs_i) | (uses_rt_s & (ex_q.wreg == bus.id_rt_i)));
        flush_s   = bus.mem_br_taken_i;
        stall_s   = LU_ON & bus.id_valid_i & hazard_s & ~flush_s;
    end

    // Next-state selection with priority flush > stall > advance
    always_comb begin
        wb_d  = mem_to_wb(mem_q);
        mem_d = {$bits(mem_t){1'b0}};
        ex_d  = {$bits(ex_t){1'b0}};
        if (flush_s) begin
            mem_d = {$bits(mem_t){1'b0}};
            ex_d  = {$bits(ex_t){1'b0}};
        end else if (stall_s) begin
            mem_d = ex_to_mem(ex_q);
            ex_d  = {$bits(ex_t){1'b0}};
        end else begin
            mem_d = ex_to_mem(ex_q);
            ex_d  = id_ex_s;
        end
    end

    // Stage registers and saturating event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q        <= {$bits(ex_t){1'b0}};
            mem_q       <= {$bits(mem_t){1'b0}};
            wb_q        <= {$bits(wb_t){1'b0}};
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            if (stall_s && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end else begin
                stall_cnt_q <= stall_cnt_q;
            end
            if (flush_s && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
            end else begin
                flush_cnt_q <= flush_cnt_q;
            end
        end
    end

    // Hazard controls act in the current cycle, so they stay combinational
    assign bus.stall_o        = stall_s;
    assign bus.flush_o        = flush_s;

    // Stage outputs come straight from the registers; a bubble is all zero
    assign bus.ex_RegDst_o    = ex_q.reg_dst;
    assign bus.ex_ALUSrc_o    = ex_q.alu_src;
    assign bus.ex_ALUop_o     = ex_q.alu_op;
    assign bus.ex_wreg_o      = ex_q.wreg;
    assign bus.fwd_a_o        = fwd_sel(ex_q.rs, mem_q, wb_q);
    assign bus.fwd_b_o        = fwd_sel(ex_q.rt, mem_q, wb_q);

    assign bus.mem_Branch_o   = mem_q.branch;
    assign bus.mem_MemRead_o  = mem_q.mem_read;
    assign bus.mem_MemWrite_o = mem_q.mem_write;
    assign bus.mem_wreg_o     = mem_q.wreg;

    assign bus.wb_RegWrite_o  = wb_q.reg_write;
    assign bus.wb_MemtoReg_o  = wb_q.memto_reg;
    assign bus.wb_wreg_o      = wb_q.wreg;

    assign bus.stall_cnt_o    = stall_cnt_q;
    assign bus.flush_cnt_o    = flush_cnt_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// -----------------------------------------------------------------------------
// tb_ctrl_pipeline
// Directed bench for ctrl_pipeline. Register writes reaching WB are checked
// against a scoreboard queue filled when each instruction is issued; hazard,
// forwarding, counter and reset behaviour is checked directly at each step.
// The DUT uses CNT_W=2 so counter saturation is reachable in a few cycles.
// -----------------------------------------------------------------------------
module tb_ctrl_pipeline;
    localparam int REG_W   = 5;
    localparam int ALUOP_W = 2;
    localparam int CNT_W   = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ctrl_pipeline_if #(.REG_W(REG_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) bus ();

    ctrl_pipeline #(.REG_W(REG_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W), .LU_EN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    logic [5:0] sb [$];      // {MemtoReg, wreg} of each write expected at WB
    logic [5:0] sb_exp;
    int         sat_exp [5] = '{1, 2, 3, 3, 3};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_id(input logic v, input logic rdst, input logic rw, input logic asrc,
                          input logic br, input logic mr, input logic mw, input logic m2r,
                          input logic [1:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd);
        bus.id_valid_i    = v;
        bus.id_RegDst_i   = rdst;
        bus.id_RegWrite_i = rw;
        bus.id_ALUSrc_i   = asrc;
        bus.id_Branch_i   = br;
        bus.id_MemRead_i  = mr;
        bus.id_MemWrite_i = mw;
        bus.id_MemtoReg_i = m2r;
        bus.id_ALUop_i    = op;
        bus.id_rs_i       = rs;
        bus.id_rt_i       = rt;
        bus.id_rd_i       = rd;
    endtask

    task automatic nop();
        set_id(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0);
    endtask
    task automatic rtype(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        set_id(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, rs, rt, rd);
    endtask
    task automatic lw(input logic [4:0] rt, input logic [4:0] rs);
        set_id(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, rs, rt, 5'd0);
    endtask
    task automatic addi(input logic [4:0] rt, input logic [4:0] rs);
        set_id(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, rs, rt, 5'd0);
    endtask
    task automatic beq(input logic [4:0] rs, input logic [4:0] rt);
        set_id(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, rs, rt, 5'd0);
    endtask
    task automatic push(input logic m2r, input logic [4:0] wreg);
        sb.push_back({m2r, wreg});
    endtask

    // Scoreboard: every register write seen at WB must match the oldest expected one
    always @(negedge clk) begin
        if (!rst && bus.wb_RegWrite_o) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL sb_underflow observed wb_wreg=%0d expected=no pending write", bus.wb_wreg_o);
            end else begin
                sb_exp = sb.pop_front();
                chk("sb_wb", {26'd0, bus.wb_MemtoReg_o, bus.wb_wreg_o}, {26'd0, sb_exp});
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.mem_br_taken_i = 1'b0;
        nop();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ex_wreg",     bus.ex_wreg_o,     0);
        chk("rst_wb_regwrite", bus.wb_RegWrite_o, 0);
        chk("rst_stall",       bus.stall_o,       0);
        chk("rst_flush",       bus.flush_o,       0);
        chk("rst_stall_cnt",   bus.stall_cnt_o,   0);
        rst = 1'b0;

        // 1: add r3,r1,r2 walks EX -> MEM -> WB
        rtype(5'd3, 5'd1, 5'd2); push(1'b0, 5'd3);
        cyc(); nop();
        chk("t1_ex_wreg",   bus.ex_wreg_o,   3);
        chk("t1_ex_regdst", bus.ex_RegDst_o, 1);
        chk("t1_ex_aluop",  bus.ex_ALUop_o,  2);
        cyc();
        chk("t1_mem_wreg",  bus.mem_wreg_o,  3);
        chk("t1_ex_bubble", bus.ex_wreg_o,   0);
        cyc();
        chk("t1_wb_regwrite", bus.wb_RegWrite_o, 1);
        chk("t1_wb_wreg",     bus.wb_wreg_o,     3);

        // 2: lw r2 then add r4,r2,r5 -> one stall, bubble, then WB forward
        lw(5'd2, 5'd1); push(1'b1, 5'd2);
        cyc();
        rtype(5'd4, 5'd2, 5'd5); push(1'b0, 5'd4);
        #1;
        chk("t2_stall",        bus.stall_o,     1);
        chk("t2_stall_cnt0",   bus.stall_cnt_o, 0);
        cyc();
        #1;
        chk("t2_stall_clear",  bus.stall_o,       0);
        chk("t2_ex_bubble",    bus.ex_wreg_o,     0);
        chk("t2_mem_memread",  bus.mem_MemRead_o, 1);
        chk("t2_mem_wreg",     bus.mem_wreg_o,    2);
        chk("t2_stall_cnt1",   bus.stall_cnt_o,   1);
        cyc(); nop();
        chk("t2_fwd_a",        bus.fwd_a_o,   2'b01);
        chk("t2_fwd_b",        bus.fwd_b_o,   2'b00);
        chk("t2_ex_wreg",      bus.ex_wreg_o, 4);

        // 2b: immediate-form reader of rt is not a load-use hazard
        cyc();
        lw(5'd2, 5'd1); push(1'b1, 5'd2);
        cyc();
        addi(5'd2, 5'd5); push(1'b0, 5'd2);
        #1;
        chk("t2b_no_stall", bus.stall_o, 0);
        cyc(); nop();

        // 3a: back-to-back dependency forwards from MEM
        cyc();
        rtype(5'd3, 5'd1, 5'd2); push(1'b0, 5'd3);
        cyc();
        rtype(5'd6, 5'd3, 5'd3); push(1'b0, 5'd6);
        cyc(); nop();
        chk("t3a_fwd_a", bus.fwd_a_o, 2'b10);
        chk("t3a_fwd_b", bus.fwd_b_o, 2'b10);

        // 3b: one nop in between forwards from WB
        cyc();
        rtype(5'd3, 5'd1, 5'd2); push(1'b0, 5'd3);
        cyc(); nop();
        cyc();
        rtype(5'd6, 5'd3, 5'd3); push(1'b0, 5'd6);
        cyc(); nop();
        chk("t3b_fwd_a", bus.fwd_a_o, 2'b01);
        chk("t3b_fwd_b", bus.fwd_b_o, 2'b01);

        // 3c: destination r0 is never forwarded
        rtype(5'd0, 5'd1, 5'd2); push(1'b0, 5'd0);
        cyc();
        rtype(5'd6, 5'd0, 5'd0); push(1'b0, 5'd6);
        cyc(); nop();
        chk("t3c_fwd_a", bus.fwd_a_o, 2'b00);
        chk("t3c_fwd_b", bus.fwd_b_o, 2'b00);

        // 3d: operand A from MEM, operand B from WB in the same cycle
        rtype(5'd3, 5'd1, 5'd2); push(1'b0, 5'd3);
        cyc();
        rtype(5'd5, 5'd1, 5'd2); push(1'b0, 5'd5);
        cyc();
        rtype(5'd6, 5'd5, 5'd3); push(1'b0, 5'd6);
        cyc(); nop();
        chk("t3d_fwd_a", bus.fwd_a_o, 2'b10);
        chk("t3d_fwd_b", bus.fwd_b_o, 2'b01);

        // 3e: same register in MEM and WB -> MEM wins
        rtype(5'd3, 5'd1, 5'd2); push(1'b0, 5'd3);
        cyc();
        rtype(5'd3, 5'd4, 5'd4); push(1'b0, 5'd3);
        cyc();
        rtype(5'd6, 5'd3, 5'd3); push(1'b0, 5'd6);
        cyc(); nop();
        chk("t3e_fwd_a", bus.fwd_a_o, 2'b10);
        chk("t3e_fwd_b", bus.fwd_b_o, 2'b10);

        // 4: taken branch in MEM while a load-use hazard sits in ID -> flush wins
        cyc();
        beq(5'd1, 5'd2);
        cyc();
        lw(5'd2, 5'd1);
        cyc();
        rtype(5'd4, 5'd2, 5'd5);
        #1;
        chk("t4_hazard_present", bus.stall_o, 1);
        bus.mem_br_taken_i = 1'b1;
        #1;
        chk("t4_flush",          bus.flush_o, 1);
        chk("t4_stall_masked",   bus.stall_o, 0);
        cyc();
        bus.mem_br_taken_i = 1'b0;
        nop();
        #1;
        chk("t4_flush_clear",    bus.flush_o,       0);
        chk("t4_ex_bubble",      bus.ex_wreg_o,     0);
        chk("t4_mem_branch",     bus.mem_Branch_o,  0);
        chk("t4_mem_memread",    bus.mem_MemRead_o, 0);
        chk("t4_mem_wreg",       bus.mem_wreg_o,    0);
        chk("t4_flush_cnt",      bus.flush_cnt_o,   1);
        chk("t4_stall_cnt_hold", bus.stall_cnt_o,   1);

        // 6: asynchronous reset between edges clears everything at once
        repeat (3) cyc();
        rtype(5'd7, 5'd1, 5'd2);
        cyc();
        rtype(5'd8, 5'd1, 5'd2);
        cyc(); nop();
        chk("t6_pre_mem_wreg", bus.mem_wreg_o, 7);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_ex_wreg",   bus.ex_wreg_o,   0);
        chk("t6_ex_regdst", bus.ex_RegDst_o, 0);
        chk("t6_mem_wreg",  bus.mem_wreg_o,  0);
        chk("t6_stall_cnt", bus.stall_cnt_o, 0);
        chk("t6_flush_cnt", bus.flush_cnt_o, 0);
        cyc();
        rst = 1'b0;
        rtype(5'd3, 5'd1, 5'd2); push(1'b0, 5'd3);
        cyc(); nop();
        cyc();
        cyc();
        chk("t6_refill_wb_regwrite", bus.wb_RegWrite_o, 1);
        chk("t6_refill_wb_wreg",     bus.wb_wreg_o,     3);

        // 5: repeated lw r2,0(r2) stalls every other cycle; 2-bit counter saturates
        lw(5'd2, 5'd2);
        for (int k = 0; k < 5; k++) begin
            push(1'b1, 5'd2);
            cyc();
            #1;
            chk("t5_stall", bus.stall_o, 1);
            cyc();
            chk("t5_stall_cnt", bus.stall_cnt_o, sat_exp[k]);
        end
        nop();
        repeat (5) cyc();
        chk("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
